// File: rtl/periph_bus_master.sv
// Initiator for the peripheral register bus: takes one command on a valid/ready channel,
// issues a single write/read strobe and returns one response, with an optional bus_ready timeout.
module periph_bus_master #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              busy
);

    // With the timeout disabled the counter is a single bit that only saturates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        STROBE   = 3'd2,
        CAPTURE  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             write_reg;
    logic [CNT_W-1:0] count_reg;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_reg == CNT_LAST) && !bus_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bus_ready) begin
                    state_next = STROBE;
                end else if (timeout_hit) begin
                    state_next = RESP;
                end
            end
            STROBE:  state_next = write_reg ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and strobe outputs depend on registers only, never on inputs.
    always_comb begin
        req_ready = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        bus_we    = (state_reg == STROBE) && write_reg;
        bus_re    = (state_reg == STROBE) && !write_reg;
        rsp_valid = (state_reg == RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_reg <= 1'b0;
            count_reg <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        bus_addr  <= req_addr;
                        bus_wdata <= req_write ? req_wdata : '0;
                        count_reg <= '0;
                    end
                end
                WAIT_RDY: begin
                    if (!bus_ready) begin
                        if (timeout_hit) begin
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (count_reg != CNT_MAX) begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                    end
                end
                STROBE: begin
                    if (write_reg) begin
                        rsp_rdata <= '0;
                        rsp_error <= 1'b0;
                    end
                end
                CAPTURE: begin
                    rsp_rdata <= bus_rdata;
                    rsp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_master.sv
// Bench for periph_bus_master: per-command timeline model (strobe/response cycles derived
// from the bus_ready delay and response back-pressure) checked against the DUT every cycle.
module tb_periph_bus_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_we;
    logic          bus_re;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ready = 1'b0;
    logic          busy;

    periph_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          chk_en = 1'b0;
    logic          e_req_ready, e_busy, e_we, e_re, e_rsp_valid, e_rsp_error;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [AW-1:0] cur_addr  = '0;
    logic [DW-1:0] cur_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 64'(req_ready), 64'(e_req_ready));
            check("busy", 64'(busy), 64'(e_busy));
            check("bus_we", 64'(bus_we), 64'(e_we));
            check("bus_re", 64'(bus_re), 64'(e_re));
            check("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
            check("bus_addr", 64'(bus_addr), 64'(e_addr));
            check("bus_wdata", 64'(bus_wdata), 64'(e_wdata));
            if (e_rsp_valid) begin
                check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
                check("rsp_error", 64'(rsp_error), 64'(e_rsp_error));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        bus_ready = 1'($urandom);
        rsp_ready = 1'($urandom);
        bus_rdata = $urandom;
        e_req_ready = 1'b1; e_busy = 1'b0; e_we = 1'b0; e_re = 1'b0; e_rsp_valid = 1'b0;
        e_rsp_error = 1'b0; e_rdata = '0;
        e_addr = cur_addr; e_wdata = cur_wdata;
        step();
    endtask

    // One command: d = bus_ready low cycles in WAIT_RDY, r = rsp_ready low cycles in RESP.
    // Cycle 0 is the accepting IDLE cycle.
    task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int d, input int r, input bit force_req,
                          input bit fix_rd, input logic [DW-1:0] rd_val,
                          output int r0_out, output logic [DW-1:0] rd_out);
        bit            to;
        int            s;
        int            r0;
        logic [DW-1:0] exp_rd;
        to     = (TO != 0) && (d >= TO);
        s      = d + 2;
        r0     = to ? TO + 1 : (wr ? d + 3 : d + 4);
        exp_rd = '0;
        for (int j = 0; j <= r0 + r; j++) begin
            bus_rdata = $urandom;
            if (fix_rd && j == d + 3) bus_rdata = rd_val;
            if (j == 0) begin
                req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
            end else begin
                req_valid = force_req | 1'($urandom);
                req_write = 1'($urandom);
                req_addr  = AW'($urandom);
                req_wdata = $urandom;
            end
            if (j >= 1 && j <= d)  bus_ready = 1'b0;
            else if (j == d + 1)   bus_ready = 1'b1;
            else                   bus_ready = 1'($urandom);
            if (j < r0) rsp_ready = 1'($urandom);
            else        rsp_ready = (j == r0 + r);
            if (!to && !wr && j == d + 3) exp_rd = bus_rdata;
            e_req_ready = (j == 0);
            e_busy      = (j != 0);
            e_we        = !to && wr && (j == s);
            e_re        = !to && !wr && (j == s);
            e_rsp_valid = (j >= r0);
            e_rsp_error = to;
            e_rdata     = exp_rd;
            if (j >= 1) begin
                e_addr  = a;
                e_wdata = wr ? wd : '0;
            end else begin
                e_addr  = cur_addr;
                e_wdata = cur_wdata;
            end
            step();
        end
        cur_addr  = a;
        cur_wdata = wr ? wd : '0;
        r0_out    = r0;
        rd_out    = exp_rd;
        $display("txn %s addr=%h wdata=%h d=%0d r=%0d err=%0b rdata=%h",
                 wr ? "WR" : "RD", a, wd, d, r, to, exp_rd);
    endtask

    initial begin
        int            r0;
        logic [DW-1:0] rd;

        // Reset state
        step(); step();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({bus_we, bus_re}), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_error}), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_addr", 64'(bus_addr), 64'd0);
        check("rst_wdata", 64'(bus_wdata), 64'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        idle_cycle();

        // Directed: write, read, delayed ready, timeout boundaries, held response
        do_txn(1'b1, 16'h0000, 32'h0000_00A5, 0, 0, 1'b0, 1'b0, '0, r0, rd);
        check("t1_rsp_cycle", 64'(r0), 64'd3);
        do_txn(1'b0, 16'h0004, 32'h0, 0, 0, 1'b0, 1'b1, 32'h0000_00FF, r0, rd);
        check("t2_rsp_cycle", 64'(r0), 64'd4);
        check("t2_rdata", 64'(rd), 64'h0000_00FF);
        do_txn(1'b1, 16'h0010, 32'h1234_5678, 5, 1, 1'b0, 1'b0, '0, r0, rd);
        check("t3_rsp_cycle", 64'(r0), 64'd8);
        do_txn(1'b0, 16'h0020, 32'h0, 20, 0, 1'b0, 1'b0, '0, r0, rd);
        check("t4_rsp_cycle", 64'(r0), 64'd17);
        do_txn(1'b1, 16'h0024, 32'hDEAD_BEEF, 16, 0, 1'b0, 1'b0, '0, r0, rd);
        do_txn(1'b0, 16'h0028, 32'h0, 15, 0, 1'b0, 1'b1, 32'hCAFE_F00D, r0, rd);
        check("t4b_no_timeout", 64'(r0), 64'd19);
        do_txn(1'b0, 16'h0030, 32'h0, 0, 10, 1'b1, 1'b1, 32'h5A5A_0001, r0, rd);
        idle_cycle();

        // Randomized commands
        for (int t = 0; t < 40; t++) begin
            int d;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 7) d = int'($urandom_range(0, 3));
            else         d = int'($urandom_range(14, 18));
            do_txn(1'($urandom), AW'($urandom), $urandom, d, int'($urandom_range(0, 3)),
                   1'b0, 1'b0, '0, r0, rd);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle();
        end

        // Asynchronous reset during STROBE
        chk_en    = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 32'h0000_0077;
        bus_ready = 1'b1; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("t6_we_before", 64'(bus_we), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_we_drop", 64'({bus_we, bus_re}), 64'd0);
        check("t6_busy_drop", 64'(busy), 64'd0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_busy", 64'(busy), 64'd0);
            check("t6_req_ready", 64'(req_ready), 64'd1);
            check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
            check("t6_addr", 64'(bus_addr), 64'd0);
        end
        cur_addr  = '0;
        cur_wdata = '0;
        chk_en    = 1'b1;
        idle_cycle();
        do_txn(1'b0, 16'h0044, 32'h0, 1, 0, 1'b0, 1'b0, '0, r0, rd);
        idle_cycle();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
